prog_mem_loadable: RTL and testbench
====================================

// Module: prog_mem_loadable
// PURPOSE
//  Parametrised synchronous program memory for the DAPA core, replacing the fixed combinational ROM.
//  Holds DEPTH instruction words of DATA_W bits. Fetch port: registered read, 1-cycle latency.
//  Load port: block-load FSM with valid/ready handshake, auto-incrementing write pointer and a running checksum.
//  The debug/UART loader drives the load port to download programs without resynthesis.
// PARAMETERS
//  DATA_W  16   instruction word width (opcode+reg+operand)
//  ADDR_W  8    fetch/load address width
//  DEPTH   256  implemented words (<= 2**ADDR_W); addresses >= DEPTH are unmapped
// PORTS
//  clk       in   1         system clock, all state on rising edge
//  reset     in   1         asynchronous, active-high; clears control state only
//  rd_en     in   1         fetch request for rd_addr
//  rd_addr   in   ADDR_W    fetch address
//  rd_data   out  DATA_W    fetched word, registered
//  rd_valid  out  1         rd_data updated this cycle (1-cycle pulse per accepted fetch)
//  ld_start  in   1         begin block load (sampled in IDLE only)
//  ld_base   in   ADDR_W    first write address, captured with ld_start
//  ld_count  in   ADDR_W+1  word count, captured with ld_start (0..2**ADDR_W)
//  ld_valid  in   1         ld_data holds a word to write
//  ld_data   in   DATA_W    load word
//  ld_ready  out  1         block accepts a word; transfer = ld_valid & ld_ready
//  ld_done   out  1         1-cycle pulse: block load complete
//  busy      out  1         FSM not in IDLE; fetches ignored
//  ld_sum    out  DATA_W    sum mod 2**DATA_W of words accepted in current/last load
// BEHAVIOUR
//  Reset (async): state=IDLE; rd_data=0, rd_valid=0, ld_ready=0, ld_done=0, busy=0, ld_sum=0,
//   ptr=0, remaining=0. Memory array is NOT cleared; contents survive reset.
//  FSM states IDLE, LOAD, DONE:
//   IDLE: ld_start & ld_count!=0 -> LOAD; ptr<=ld_base, remaining<=ld_count, ld_sum<=0.
//         ld_start & ld_count==0 -> DONE (no writes), ld_sum<=0.
//   LOAD: ld_ready=1 (combinational from state). Each transfer: mem[ptr]<=ld_data if ptr<DEPTH,
//         else write dropped but still counted; ptr<=ptr+1 mod 2**ADDR_W (wraps 0xFF->0x00);
//         ld_sum<=ld_sum+ld_data mod 2**DATA_W; remaining<=remaining-1.
//         Transfer with remaining==1 -> DONE. ld_valid low: stall indefinitely, no state change.
//         ld_start in LOAD/DONE ignored.
//   DONE: ld_done=1, ld_ready=0 for exactly one cycle -> IDLE.
//  busy=1 in LOAD and DONE. ld_sum holds after DONE until next accepted ld_start or reset.
//  Fetch: rd_en & state==IDLE in cycle N -> rd_data = mem[rd_addr] (0 if rd_addr>=DEPTH),
//   rd_valid=1 in cycle N+1. Back-to-back fetches every cycle supported.
//  rd_en while busy: ignored; rd_valid=0 next cycle. rd_data holds previous value whenever rd_valid=0.
//  ld_start and rd_en in the same IDLE cycle: fetch served (rd_valid next cycle) and load starts.
//  Memory contents before any load are undefined (sim: X); read after write to same address
//   in a later cycle returns the new word.
//  Reset mid-LOAD: back to IDLE immediately; already-written words remain; no ld_done pulse.
// TESTING
//  T1 reset, ld_start base=0x00 count=3, words 0x2081,0x3080,0xF800 with ld_valid high
//     -> ld_ready 3 cycles, ld_done pulse 1 cycle later, ld_sum=0x4901; fetch 0,1,2 returns the words, rd_valid at N+1.
//  T2 load base=0xFE count=4, ld_valid toggled 1/0 -> writes at 0xFE,0xFF,0x00,0x01 (wrap), ld_ready stalls without loss.
//  T3 DEPTH=128, load base=0x7F count=2 -> mem[0x7F] written, 0x80 dropped; fetch 0x80 -> rd_data=0, ld_sum counts both.
//  T4 rd_en during LOAD -> rd_valid stays 0, rd_data unchanged; ld_start during LOAD ignored; ld_count=0 -> ld_done 1 cycle after start.
//  T5 assert reset after 2 of 5 words -> all outputs at reset values asynchronously, words 0..1 readable afterwards, no ld_done.
//  T6 rd_en every cycle over 0..15 in IDLE -> 16 consecutive rd_valid pulses, data in address order.

Source files
------------

// File: rtl/prog_mem_loadable_if.sv
// ---------------------------------------------------------------------------
// prog_mem_loadable_if
//   Bundles the fetch port and the block-load port of prog_mem_loadable.
//
//   Fetch side : rd_en, rd_addr  -> memory
//                rd_data, rd_valid <- memory
//   Load side  : ld_start, ld_base, ld_count, ld_valid, ld_data -> memory
//                ld_ready, ld_done, busy, ld_sum               <- memory
//
//   Handshake: a load word moves on every rising clock edge where
//   ld_valid & ld_ready are both high. The master holds ld_data stable while
//   ld_valid is high and ld_ready is low; ld_ready does not depend on ld_valid.
//
//   master : the CPU fetch unit / debug loader side (drives requests)
//   slave  : the program memory (drives responses)
// ---------------------------------------------------------------------------
interface prog_mem_loadable_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    // Fetch port
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    // Load port
    logic              ld_start;
    logic [ADDR_W-1:0] ld_base;
    logic [ADDR_W:0]   ld_count;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              ld_done;
    logic              busy;
    logic [DATA_W-1:0] ld_sum;

    modport master (
        output rd_en, rd_addr,
        input  rd_data, rd_valid,
        output ld_start, ld_base, ld_count, ld_valid, ld_data,
        input  ld_ready, ld_done, busy, ld_sum
    );

    modport slave (
        input  rd_en, rd_addr,
        output rd_data, rd_valid,
        input  ld_start, ld_base, ld_count, ld_valid, ld_data,
        output ld_ready, ld_done, busy, ld_sum
    );
endinterface

// File: rtl/prog_mem_loadable.sv
// ---------------------------------------------------------------------------
// prog_mem_loadable
//   Loadable synchronous program memory for the DAPA core. Holds DEPTH words
//   of DATA_W bits. Fetches are registered (data one cycle after the request);
//   programs are downloaded through a block-load FSM that auto-increments the
//   write pointer and keeps a running checksum of the accepted words.
//
// Ports
//   clk          in   system clock, all state on the rising edge
//   reset        in   asynchronous, active-high; clears control state only,
//                     the memory array keeps its contents
//   bus          slave modport of prog_mem_loadable_if (fetch + load ports)
//   dbg_state_o  out  current FSM state (0 IDLE, 1 LOAD, 2 DONE)
//
// Behaviour summary
//   IDLE : fetches are served; ld_start captures base/count and enters LOAD
//          (or DONE directly for a zero-length block).
//   LOAD : ld_ready high; each transfer writes mem[ptr] (dropped when ptr is
//          unmapped but still counted), bumps ptr (wrapping), adds the word
//          to ld_sum and decrements the remaining count.
//   DONE : single-cycle ld_done pulse, then back to IDLE.
//   busy is high in LOAD and DONE; fetch requests are ignored while busy.
// ---------------------------------------------------------------------------
module prog_mem_loadable #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                clk,
    input  logic                reset,
    prog_mem_loadable_if.slave  bus,
    output logic [1:0]          dbg_state_o
);

    // Index width of the implemented array; addresses above it are compared
    // against DEPTH as a whole so unmapped addresses never alias.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Storage (no reset: program survives a control reset)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // Registered state and outputs
    // ------------------------------------------------------------------
    state_t            state_q,     state_d;
    logic [ADDR_W-1:0] ptr_q,       ptr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic [DATA_W-1:0] sum_q,       sum_d;
    logic [DATA_W-1:0] rd_data_q,   rd_data_d;
    logic              rd_valid_q,  rd_valid_d;
    logic              ld_ready_q,  ld_ready_d;
    logic              ld_done_q,   ld_done_d;
    logic              busy_q,      busy_d;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic              rd_in_range;
    logic              wr_in_range;
    logic [DATA_W-1:0] rd_word;
    logic              transfer;
    logic              last_word;

    assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_L);
    assign wr_in_range = ({1'b0, ptr_q} < DEPTH_L);
    assign rd_word     = mem[bus.rd_addr[IDX_W-1:0]];

    // ld_ready_q is high exactly while in LOAD, so this is the handshake.
    assign transfer  = ld_ready_q & bus.ld_valid;
    assign last_word = (remaining_q == {{ADDR_W{1'b0}}, 1'b1});

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        sum_d       = sum_q;
        rd_data_d   = rd_data_q;   // rd_data holds whenever no fetch completes
        rd_valid_d  = 1'b0;
        ld_ready_d  = ld_ready_q;
        ld_done_d   = 1'b0;
        busy_d      = busy_q;

        case (state_q)
            ST_IDLE: begin
                // A fetch and a load start in the same cycle are both honoured.
                if (bus.rd_en) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = rd_in_range ? rd_word : '0;
                end
                if (bus.ld_start) begin
                    sum_d  = '0;
                    busy_d = 1'b1;
                    if (bus.ld_count != '0) begin
                        state_d     = ST_LOAD;
                        ptr_d       = bus.ld_base;
                        remaining_d = bus.ld_count;
                        ld_ready_d  = 1'b1;
                    end else begin
                        // Empty block: report completion without any write.
                        state_d   = ST_DONE;
                        ld_done_d = 1'b1;
                    end
                end
            end

            ST_LOAD: begin
                if (transfer) begin
                    ptr_d       = ptr_q + 1'b1;   // wraps at 2**ADDR_W
                    sum_d       = sum_q + bus.ld_data;
                    remaining_d = remaining_q - 1'b1;
                    if (last_word) begin
                        state_d    = ST_DONE;
                        ld_ready_d = 1'b0;
                        ld_done_d  = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d    = ST_IDLE;
                ld_ready_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            sum_q       <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            ld_ready_q  <= 1'b0;
            ld_done_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            sum_q       <= sum_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            ld_ready_q  <= ld_ready_d;
            ld_done_q   <= ld_done_d;
            busy_q      <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Memory write port: unmapped pointer values drop the word silently
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (transfer && wr_in_range) begin
            mem[ptr_q[IDX_W-1:0]] <= bus.ld_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.ld_ready = ld_ready_q;
    assign bus.ld_done  = ld_done_q;
    assign bus.busy     = busy_q;
    assign bus.ld_sum   = sum_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_prog_mem_loadable.sv
// ---------------------------------------------------------------------------
// tb_prog_mem_loadable
//   Two instances share one stimulus stream: dut0 fully mapped (DEPTH=256),
//   dut1 half mapped (DEPTH=128). Fetch results are checked by a scoreboard
//   fed from a bench-side memory model; control outputs are checked inline.
// ---------------------------------------------------------------------------
module tb_prog_mem_loadable;

    logic clk;
    logic reset;
    logic [1:0] dbg0;
    logic [1:0] dbg1;

    prog_mem_loadable_if #(.DATA_W(16), .ADDR_W(8)) bus0 ();
    prog_mem_loadable_if #(.DATA_W(16), .ADDR_W(8)) bus1 ();

    // dut1 sees exactly the same requests as dut0
    assign bus1.rd_en    = bus0.rd_en;
    assign bus1.rd_addr  = bus0.rd_addr;
    assign bus1.ld_start = bus0.ld_start;
    assign bus1.ld_base  = bus0.ld_base;
    assign bus1.ld_count = bus0.ld_count;
    assign bus1.ld_valid = bus0.ld_valid;
    assign bus1.ld_data  = bus0.ld_data;

    prog_mem_loadable #(.DATA_W(16), .ADDR_W(8), .DEPTH(256)) dut0 (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus0),
        .dbg_state_o (dbg0)
    );

    prog_mem_loadable #(.DATA_W(16), .ADDR_W(8), .DEPTH(128)) dut1 (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus1),
        .dbg_state_o (dbg1)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;
    int pops0 = 0;
    int pops1 = 0;

    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];
    logic [15:0] m0 [256];
    logic [15:0] m1 [128];
    logic [15:0] wbuf [16];
    logic [15:0] mon_e0;
    logic [15:0] mon_e1;

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        if (bus0.rd_valid === 1'b1) begin
            n_checks++;
            if (exp_q0.size() == 0) begin
                n_errors++;
                $display("FAIL dut0_unexpected_rd_valid: rd_data=%h, no fetch outstanding", bus0.rd_data);
            end else begin
                mon_e0 = exp_q0.pop_front();
                pops0++;
                if (bus0.rd_data !== mon_e0) begin
                    n_errors++;
                    $display("FAIL dut0_rd_data: got %h expected %h", bus0.rd_data, mon_e0);
                end
            end
        end
        if (bus1.rd_valid === 1'b1) begin
            n_checks++;
            if (exp_q1.size() == 0) begin
                n_errors++;
                $display("FAIL dut1_unexpected_rd_valid: rd_data=%h, no fetch outstanding", bus1.rd_data);
            end else begin
                mon_e1 = exp_q1.pop_front();
                pops1++;
                if (bus1.rd_data !== mon_e1) begin
                    n_errors++;
                    $display("FAIL dut1_rd_data: got %h expected %h", bus1.rd_data, mon_e1);
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_fetch(input logic [7:0] a);
        exp_q0.push_back(m0[a]);
        exp_q1.push_back((a < 8'd128) ? m1[a[6:0]] : 16'h0000);
    endtask

    task automatic model_write(input logic [7:0] a, input logic [15:0] w);
        m0[a] = w;
        if (a < 8'd128) m1[a[6:0]] = w;
    endtask

    // Single fetch in IDLE: checks N+1 latency and the hold afterwards.
    task automatic fetch_one(input logic [7:0] a);
        bus0.rd_en   = 1'b1;
        bus0.rd_addr = a;
        push_fetch(a);
        tick();
        bus0.rd_en = 1'b0;
        n_checks++;
        if (bus0.rd_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL fetch_latency addr %h: rd_valid=%b expected 1", a, bus0.rd_valid);
        end
        tick();
        n_checks++;
        if (bus0.rd_valid !== 1'b0 || bus0.rd_data !== m0[a]) begin
            n_errors++;
            $display("FAIL fetch_hold addr %h: rd_valid=%b rd_data=%h expected 0/%h",
                     a, bus0.rd_valid, bus0.rd_data, m0[a]);
        end
    endtask

    // Block load of wbuf[0..count-1]; optional idle cycle between words.
    task automatic load_block(input logic [7:0] base, input int count, input bit toggle);
        logic [15:0] s;
        logic [7:0]  p;
        int          rdy;
        s   = 16'h0;
        p   = base;
        rdy = 0;
        bus0.ld_start = 1'b1;
        bus0.ld_base  = base;
        bus0.ld_count = 9'(count);
        tick();
        bus0.ld_start = 1'b0;
        n_checks++;
        if (bus0.busy !== 1'b1 || bus0.ld_ready !== 1'b1 || dbg0 !== 2'd1) begin
            n_errors++;
            $display("FAIL load_enter: busy=%b ld_ready=%b state=%0d expected 1/1/1",
                     bus0.busy, bus0.ld_ready, dbg0);
        end
        for (int i = 0; i < count; i++) begin
            bus0.ld_valid = 1'b1;
            bus0.ld_data  = wbuf[i];
            if (bus0.ld_ready === 1'b1) rdy++;
            tick();
            model_write(p, wbuf[i]);
            s = s + wbuf[i];
            p = p + 8'd1;
            if (toggle && i != count - 1) begin
                bus0.ld_valid = 1'b0;
                bus0.ld_data  = 16'($urandom_range(0, 65535));
                tick();
                n_checks++;
                if (bus0.ld_ready !== 1'b1 || bus0.ld_done !== 1'b0) begin
                    n_errors++;
                    $display("FAIL load_stall word %0d: ld_ready=%b ld_done=%b expected 1/0",
                             i, bus0.ld_ready, bus0.ld_done);
                end
            end
        end
        bus0.ld_valid = 1'b0;
        n_checks++;
        if (bus0.ld_done !== 1'b1 || bus0.ld_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL load_done_pulse: ld_done=%b ld_ready=%b expected 1/0",
                     bus0.ld_done, bus0.ld_ready);
        end
        n_checks++;
        if (bus0.ld_sum !== s || bus1.ld_sum !== s) begin
            n_errors++;
            $display("FAIL load_sum: dut0=%h dut1=%h expected %h", bus0.ld_sum, bus1.ld_sum, s);
        end
        n_checks++;
        if (rdy != count) begin
            n_errors++;
            $display("FAIL load_ready_cycles: got %0d expected %0d", rdy, count);
        end
        tick();
        n_checks++;
        if (bus0.ld_done !== 1'b0 || bus0.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL load_return_idle: ld_done=%b busy=%b expected 0/0",
                     bus0.ld_done, bus0.busy);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({bus0.rd_valid, bus0.ld_ready, bus0.ld_done, bus0.busy} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_flags: rd_valid/ld_ready/ld_done/busy=%b expected 0000",
                     {bus0.rd_valid, bus0.ld_ready, bus0.ld_done, bus0.busy});
        end
        n_checks++;
        if (bus0.rd_data !== 16'h0 || bus0.ld_sum !== 16'h0 || dbg0 !== 2'd0 || dbg1 !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_values: rd_data=%h ld_sum=%h state=%0d/%0d expected 0",
                     bus0.rd_data, bus0.ld_sum, dbg0, dbg1);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_load();
        wbuf[0] = 16'h2081;
        wbuf[1] = 16'h3080;
        wbuf[2] = 16'hF800;
        load_block(8'h00, 3, 1'b0);
        n_checks++;
        if (bus0.ld_sum !== 16'h4901) begin
            n_errors++;
            $display("FAIL basic_sum_const: got %h expected 4901", bus0.ld_sum);
        end
        fetch_one(8'h00);
        fetch_one(8'h01);
        fetch_one(8'h02);
    endtask

    task automatic test_wrap_stall();
        for (int i = 0; i < 4; i++) wbuf[i] = 16'($urandom_range(0, 65535));
        load_block(8'hFE, 4, 1'b1);
        fetch_one(8'hFE);
        fetch_one(8'hFF);
        fetch_one(8'h00);
        fetch_one(8'h01);
    endtask

    task automatic test_unmapped();
        wbuf[0] = 16'h1357;
        wbuf[1] = 16'h2468;
        model_write(8'h80, 16'h0000);
        load_block(8'h7F, 2, 1'b0);
        n_checks++;
        if (bus1.ld_sum !== 16'h37BF) begin
            n_errors++;
            $display("FAIL unmapped_sum: got %h expected 37bf", bus1.ld_sum);
        end
        fetch_one(8'h7F);
        fetch_one(8'h80);
    endtask

    task automatic test_busy_ignore();
        logic [15:0] prev;
        logic [15:0] w0;
        logic [15:0] w1;
        w0   = 16'($urandom_range(0, 65535));
        w1   = 16'($urandom_range(0, 65535));
        prev = bus0.rd_data;
        bus0.ld_start = 1'b1;
        bus0.ld_base  = 8'h10;
        bus0.ld_count = 9'd2;
        tick();
        // Restart attempt with a different block and a fetch while loading
        bus0.ld_count = 9'd5;
        bus0.ld_base  = 8'h40;
        bus0.rd_en    = 1'b1;
        bus0.rd_addr  = 8'h00;
        bus0.ld_valid = 1'b0;
        tick();
        n_checks++;
        if (bus0.rd_valid !== 1'b0 || bus0.rd_data !== prev) begin
            n_errors++;
            $display("FAIL rd_while_busy: rd_valid=%b rd_data=%h expected 0/%h",
                     bus0.rd_valid, bus0.rd_data, prev);
        end
        bus0.ld_valid = 1'b1;
        bus0.ld_data  = w0;
        tick();
        model_write(8'h10, w0);
        bus0.ld_data = w1;
        tick();
        model_write(8'h11, w1);
        bus0.ld_valid = 1'b0;
        bus0.ld_start = 1'b0;
        n_checks++;
        if (bus0.ld_done !== 1'b1 || bus0.ld_sum !== 16'(w0 + w1) || bus0.rd_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL start_ignored: ld_done=%b ld_sum=%h rd_valid=%b expected 1/%h/0",
                     bus0.ld_done, bus0.ld_sum, bus0.rd_valid, 16'(w0 + w1));
        end
        bus0.rd_en = 1'b0;
        tick();
        n_checks++;
        if (bus0.ld_done !== 1'b0 || bus0.busy !== 1'b0 || bus0.rd_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL done_to_idle: ld_done=%b busy=%b rd_valid=%b expected 0/0/0",
                     bus0.ld_done, bus0.busy, bus0.rd_valid);
        end
        // Zero-length load together with a fetch in the same IDLE cycle
        bus0.rd_en    = 1'b1;
        bus0.rd_addr  = 8'h10;
        push_fetch(8'h10);
        bus0.ld_start = 1'b1;
        bus0.ld_count = 9'd0;
        tick();
        bus0.rd_en    = 1'b0;
        bus0.ld_start = 1'b0;
        n_checks++;
        if (bus0.ld_done !== 1'b1 || bus0.busy !== 1'b1 || bus0.ld_ready !== 1'b0 ||
            bus0.rd_valid !== 1'b1 || bus0.ld_sum !== 16'h0) begin
            n_errors++;
            $display("FAIL zero_count: ld_done=%b busy=%b ld_ready=%b rd_valid=%b ld_sum=%h expected 1/1/0/1/0",
                     bus0.ld_done, bus0.busy, bus0.ld_ready, bus0.rd_valid, bus0.ld_sum);
        end
        tick();
        n_checks++;
        if (bus0.ld_done !== 1'b0 || bus0.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_count_end: ld_done=%b busy=%b expected 0/0", bus0.ld_done, bus0.busy);
        end
    endtask

    task automatic test_reset_mid_load();
        int done_seen;
        for (int i = 0; i < 5; i++) wbuf[i] = 16'($urandom_range(0, 65535));
        bus0.ld_start = 1'b1;
        bus0.ld_base  = 8'h20;
        bus0.ld_count = 9'd5;
        tick();
        bus0.ld_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus0.ld_valid = 1'b1;
            bus0.ld_data  = wbuf[i];
            tick();
            model_write(8'h20 + 8'(i), wbuf[i]);
        end
        bus0.ld_data = wbuf[2];
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus0.rd_valid, bus0.ld_ready, bus0.ld_done, bus0.busy} !== 4'b0000 ||
            bus0.ld_sum !== 16'h0 || bus0.rd_data !== 16'h0 || dbg0 !== 2'd0) begin
            n_errors++;
            $display("FAIL async_reset: flags=%b ld_sum=%h rd_data=%h state=%0d expected all 0",
                     {bus0.rd_valid, bus0.ld_ready, bus0.ld_done, bus0.busy},
                     bus0.ld_sum, bus0.rd_data, dbg0);
        end
        bus0.ld_valid = 1'b0;
        tick();
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus0.ld_done !== 1'b0 || bus0.busy !== 1'b0) done_seen++;
        end
        n_checks++;
        if (done_seen != 0) begin
            n_errors++;
            $display("FAIL reset_no_done: %0d cycles with ld_done/busy high, expected 0", done_seen);
        end
        fetch_one(8'h20);
        fetch_one(8'h21);
    endtask

    task automatic test_back_to_back();
        int start_pops;
        for (int i = 0; i < 16; i++) wbuf[i] = 16'($urandom_range(0, 65535));
        load_block(8'h00, 16, 1'b0);
        start_pops = pops0;
        for (int i = 0; i < 16; i++) begin
            bus0.rd_en   = 1'b1;
            bus0.rd_addr = 8'(i);
            push_fetch(8'(i));
            tick();
            n_checks++;
            if (bus0.rd_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL b2b_valid addr %0d: rd_valid=%b expected 1", i, bus0.rd_valid);
            end
        end
        bus0.rd_en = 1'b0;
        tick();
        n_checks++;
        if (bus0.rd_valid !== 1'b0 || pops0 - start_pops != 16) begin
            n_errors++;
            $display("FAIL b2b_count: rd_valid=%b pulses=%0d expected 0/16",
                     bus0.rd_valid, pops0 - start_pops);
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        reset         = 1'b1;
        bus0.rd_en    = 1'b0;
        bus0.rd_addr  = '0;
        bus0.ld_start = 1'b0;
        bus0.ld_base  = '0;
        bus0.ld_count = '0;
        bus0.ld_valid = 1'b0;
        bus0.ld_data  = '0;

        test_reset();
        test_basic_load();
        test_wrap_stall();
        test_unmapped();
        test_busy_ignore();
        test_reset_mid_load();
        test_back_to_back();

        tick();
        tick();
        n_checks++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d/%0d fetches never returned",
                     exp_q0.size(), exp_q1.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
